instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Upstream fetch stage for the multi-cycle MIPS CPU core. It holds a loadable instruction memory and the program counter, and supplies the core's `instrword`/`newinstr` inputs. It presents one instruction at a time, waits for the core to report completion, and then advances the PC either sequentially or to a branch target. Fetch stops on a halt word or on a fault.

Parameters:
- DEPTH, 128: instruction memory size in 32-bit words (power of 2).
- RESET_PC, 32'h0000_0000: PC loaded on reset and on every accepted start.
- HALT_WORD, 32'hFFFF_FFFF: instruction encoding that stops fetch.
- TIMEOUT, 16: max WAIT cycles before watchdog fault (used only with FETCH_TIMEOUT_EN).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin execution at RESET_PC; accepted only in IDLE or HALT.
- load_en  in  1  write load_data to imem[load_addr]; accepted only in IDLE or HALT.
- load_addr  in  log2(DEPTH)  word address for program load.
- load_data  in  32  program word.
- cpu_done  in  1  core has finished the current instruction (WB complete).
- branch_taken  in  1  sampled together with cpu_done; selects branch_target.
- branch_target  in  32  byte address of the next PC when branch_taken=1.
- instrword  out  32  registered instruction presented to the core.
- newinstr  out  1  one-cycle pulse: instrword is valid and new.
- pc  out  32  byte address of the instruction in instrword.
- halted  out  1  high in HALT.
- fault  out  1  sticky error: misaligned or out-of-range PC (or timeout).
- instr_count  out  16  number of issued instructions, saturating.

Behaviour:
- Reset (reset=0, async): state=IDLE; pc=RESET_PC; instrword=0; newinstr=0; halted=0; fault=0; instr_count=0. Memory contents are not cleared.
- States: IDLE, FETCH, ISSUE, WAIT, HALT.
- IDLE:
  - load_en writes memory.
  - start → FETCH with pc=RESET_PC, instr_count=0, fault=0.
  - If start and load_en are both high, the load completes first, then start is taken in the same cycle.
- FETCH (1 cycle):
  - If pc[1:0]≠0 or pc[31:2]≥DEPTH → HALT with fault=1.
  - Otherwise instrword ← imem[pc[log2(DEPTH)+1:2]].
  - If the fetched word == HALT_WORD → HALT (fault=0, no pulse).
  - Otherwise → ISSUE.
- ISSUE (1 cycle):
  - newinstr=1.
  - instr_count += 1, saturating at 16'hFFFF.
  - → WAIT.
- WAIT:
  - instrword is held stable and newinstr=0.
  - On cpu_done: pc ← branch_taken ? branch_target : pc+4 (32-bit wrap), then → FETCH.
  - cpu_done during ISSUE is ignored.
- HALT:
  - halted=1; pc and instrword are held.
  - load_en is accepted.
  - start → FETCH as from IDLE; halted clears on the next edge.
- Latency: start → newinstr pulse in 2 cycles. cpu_done → next newinstr in 2 cycles.
- Precedence: load_en and start are ignored in FETCH, ISSUE and WAIT.
- Reset asserted mid-operation aborts immediately to the reset values; a pending newinstr is dropped.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter runs.
  - If cpu_done is absent for TIMEOUT consecutive WAIT cycles → HALT with fault=1.
  - The counter clears on every entry to WAIT.
- Undefined:
  - No counter is built.
  - WAIT lasts indefinitely.
  - TIMEOUT is unused.

Test Plan:
- Load imem[0..2]={32'h0000_0020, 32'h0000_0022, 32'hFFFF_FFFF}, start, answer cpu_done 4 cycles after each newinstr → 2 pulses with pc=0 then 4; halted=1 with pc=8; instr_count=2; fault=0.
- Branch: imem[1]=32'h1000_0002; at its cpu_done assert branch_taken=1, branch_target=32'h10 → next newinstr has pc=32'h10 and instrword=imem[4].
- Misaligned target: branch_target=32'h6 → no newinstr; HALT with fault=1, pc=32'h6.
- Out of range: branch_target=32'h200 with DEPTH=128 → fault=1, halted=1.
- Reset pulled low in WAIT after 3 instructions → all outputs return to reset values asynchronously; a later start re-runs from pc=0 with instr_count counting from 0.
- FETCH_TIMEOUT_EN with TIMEOUT=16, cpu_done never asserted → halted=1 and fault=1 exactly 16 cycles after entering WAIT.
- Load/start gating: load_en and start pulsed during WAIT → memory unchanged and state unchanged.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Bus between the instruction fetch unit and the core/program loader.
// slave: the fetch unit. master: the core, loader and test environment.
interface instr_fetch_unit_if #(
  parameter int unsigned AW = 7
);
  logic          start;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          cpu_done;
  logic          branch_taken;
  logic [31:0]   branch_target;
  logic [31:0]   instrword;
  logic          newinstr;
  logic [31:0]   pc;
  logic          halted;
  logic          fault;
  logic [15:0]   instr_count;

  modport slave (
    input  start, load_en, load_addr, load_data, cpu_done, branch_taken, branch_target,
    output instrword, newinstr, pc, halted, fault, instr_count
  );

  modport master (
    output start, load_en, load_addr, load_data, cpu_done, branch_taken, branch_target,
    input  instrword, newinstr, pc, halted, fault, instr_count
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage for the multi-cycle MIPS core: loadable imem, PC, one-at-a-time issue.
// Define FETCH_TIMEOUT_EN to build the WAIT watchdog (TIMEOUT cycles without cpu_done).
module instr_fetch_unit #(
  parameter int unsigned DEPTH     = 128,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int unsigned TIMEOUT   = 16
) (
  input logic               clock,
  input logic               reset,
  instr_fetch_unit_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        newinstr_q, newinstr_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;
  logic [15:0] count_q, count_d;

  logic [31:0] imem [DEPTH];
  logic        mem_we_c;
  logic [31:0] rd_word_c;
  logic        pc_bad_c;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt_q, wcnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // Program memory: written only by the loader, never reset.
  always_ff @(posedge clock) begin
    if (mem_we_c) begin
      imem[bus.load_addr] <= bus.load_data;
    end
  end

  assign rd_word_c = imem[pc_q[AW+1:2]];
  assign pc_bad_c  = (pc_q[1:0] != 2'b00) || (32'(pc_q[31:2]) >= 32'(DEPTH));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      newinstr_q <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= 16'd0;
`ifdef FETCH_TIMEOUT_EN
      wcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      newinstr_q <= newinstr_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
`ifdef FETCH_TIMEOUT_EN
      wcnt_q     <= wcnt_d;
`endif
    end
  end

  // Next-state and registered-output logic; newinstr is set on entry to ISSUE.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    newinstr_d = 1'b0;
    halted_d   = halted_q;
    fault_d    = fault_q;
    count_d    = count_q;
    mem_we_c   = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    wcnt_d     = wcnt_q;
`endif

    unique case (state_q)
      S_IDLE, S_HALT: begin
        mem_we_c = bus.load_en;
        if (bus.start) begin
          state_d  = S_FETCH;
          pc_d     = RESET_PC;
          count_d  = 16'd0;
          fault_d  = 1'b0;
          halted_d = 1'b0;
        end
      end

      S_FETCH: begin
        if (pc_bad_c) begin
          state_d  = S_HALT;
          fault_d  = 1'b1;
          halted_d = 1'b1;
        end else begin
          instr_d = rd_word_c;
          if (rd_word_c == HALT_WORD) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            state_d    = S_ISSUE;
            newinstr_d = 1'b1;
            count_d    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          end
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end

      S_WAIT: begin
        if (bus.cpu_done) begin
          state_d = S_FETCH;
          pc_d    = bus.branch_taken ? bus.branch_target : pc_q + 32'd4;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wcnt_q == TW'(TIMEOUT - 1)) begin
          state_d  = S_HALT;
          fault_d  = 1'b1;
          halted_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.instrword   = instr_q;
  assign bus.newinstr    = newinstr_q;
  assign bus.pc          = pc_q;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;
  assign bus.instr_count = count_q;

endmodule
